pipe_ifu: RTL and testbench

Instruction fetch stage of the in-order pipeline, directly upstream of the decode stage.
- Owns the architectural fetch PC and issues one instruction-memory request at a time over a valid/ready request channel.
- Captures the response and presents {pc, inst} to decode as an ifToId_t with a valid/ready handshake.
- Accepts a flush/redirect from the back end and discards any stale in-flight fetch.

---
 rtl/pipe_ifu.sv | 113 +++++++++++
 tb/tb_pipe_ifu.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ifu.sv
// Instruction fetch stage: owns the fetch PC, keeps one imem request in flight and
// hands {pc, inst} to decode. Define IFU_FAST_ISSUE_EN to overlap the next request with the decode handshake.
module pipe_ifu #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic [XLEN-1:0]    redirect_pc_i,
    output logic               imem_req_valid_o,
    input  logic               imem_req_ready_i,
    output logic [XLEN-1:0]    imem_req_addr_o,
    input  logic               imem_rsp_valid_i,
    input  logic [31:0]        imem_rsp_data_i,
    output logic               if_valid_o,
    input  logic               id_ready_i,
    output logic [XLEN+31:0]   ifToId_o
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_t;

    state_t             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic               drop_q, drop_d;
    logic [XLEN+31:0]   ifToId_q, ifToId_d;
    logic               req_valid;
    logic [XLEN-1:0]    req_addr;
    logic               if_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            drop_q   <= 1'b0;
            ifToId_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            drop_q   <= drop_d;
            ifToId_q <= ifToId_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        ifToId_d  = ifToId_q;
        req_valid = 1'b0;
        req_addr  = pc_q;
        if_valid  = 1'b0;
        case (state_q)
            S_REQ: begin
                req_valid = !flush_i;
                if (flush_i) begin
                    pc_d = redirect_pc_i;
                end else if (imem_req_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A flush with nothing returning yet leaves drop_q set so the stale reply is eaten later.
                if (flush_i) begin
                    pc_d = redirect_pc_i;
                    if (imem_rsp_valid_i) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rsp_valid_i) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        ifToId_d = {pc_q, imem_rsp_data_i};
                        state_d  = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (flush_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = S_REQ;
                end else begin
                    if_valid = 1'b1;
                    if (id_ready_i) begin
                        pc_d    = pc_q + XLEN'(4);
                        state_d = S_REQ;
`ifdef IFU_FAST_ISSUE_EN
                        req_valid = 1'b1;
                        req_addr  = pc_q + XLEN'(4);
                        if (imem_req_ready_i) begin
                            state_d = S_WAIT;
                        end
`endif
                    end
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Request valid is masked during reset; the state register alone would already read S_REQ.
    assign imem_req_valid_o = req_valid & ~rst_i;
    assign imem_req_addr_o  = req_addr;
    assign if_valid_o       = if_valid;
    assign ifToId_o         = ifToId_q;

endmodule

// File: tb/tb_pipe_ifu.sv
// Self-checking bench for pipe_ifu: directed scenarios plus randomized traffic
// scored against a transaction-level fetch model (also handles IFU_FAST_ISSUE_EN builds).
module tb_pipe_ifu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        if_valid_o;
    logic        id_ready_i;
    logic [63:0] ifToId_o;

    pipe_ifu #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .if_valid_o       (if_valid_o),
        .id_ready_i       (id_ready_i),
        .ifToId_o         (ifToId_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;
    int hs_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Instruction memory: a response pulse mem_lat cycles after each accepted request.
    int          mem_lat   = 1;
    logic [31:0] mem_dnext = 32'h0;
    int          mem_cnt   = 0;
    logic [31:0] mem_data  = 32'h0;

    task automatic cyc(input logic fl, input logic [31:0] rp, input logic rr, input logic idr);
        @(negedge clk_i);
        if (imem_req_valid_o && imem_req_ready_i) begin
            mem_cnt  = mem_lat;
            mem_data = mem_dnext;
        end
        @(posedge clk_i);
        #1;
        flush_i          = fl;
        redirect_pc_i    = rp;
        imem_req_ready_i = rr;
        id_ready_i       = idr;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = $urandom;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rsp_valid_i = 1'b1;
                imem_rsp_data_i  = mem_data;
            end
        end
        #1;
    endtask

    // Reference model: next fetch PC, the one outstanding request, and the instruction held for decode.
    logic [31:0] m_pc;
    logic        m_os, m_stale, m_out_v;
    logic [31:0] m_os_addr;
    logic [63:0] m_out;

    always @(negedge clk_i) begin
        logic        exp_req_v;
        logic [31:0] exp_addr;
        logic        rsp;
        if (rst_i) begin
            m_pc = 32'h8000_0000; m_os = 0; m_stale = 0; m_out_v = 0; m_out = '0; m_os_addr = '0;
            chk("rst_req_valid", 64'(imem_req_valid_o), 64'(0));
            chk("rst_if_valid", 64'(if_valid_o), 64'(0));
        end else begin
            exp_req_v = !m_os && !m_out_v && !flush_i;
            exp_addr  = m_pc;
`ifdef IFU_FAST_ISSUE_EN
            if (m_out_v && id_ready_i && !flush_i) begin
                exp_req_v = 1'b1;
                exp_addr  = m_pc + 32'd4;
            end
`endif
            chk("req_valid", 64'(imem_req_valid_o), 64'(exp_req_v));
            if (exp_req_v) chk("req_addr", 64'(imem_req_addr_o), 64'(exp_addr));
            chk("if_valid", 64'(if_valid_o), 64'(m_out_v && !flush_i));
            if (m_out_v) chk("ifToId", ifToId_o, m_out);
            if (if_valid_o && id_ready_i) hs_cnt++;

            rsp = imem_rsp_valid_i && m_os;
            if (flush_i) begin
                m_pc    = redirect_pc_i;
                m_out_v = 0;
                if (rsp) begin
                    m_os = 0; m_stale = 0;
                end else if (m_os) begin
                    m_stale = 1;
                end
            end else begin
                if (rsp) begin
                    if (!m_stale) begin
                        m_out_v = 1;
                        m_out   = {m_os_addr, imem_rsp_data_i};
                    end
                    m_os = 0; m_stale = 0;
                end else if (m_out_v && id_ready_i) begin
                    m_pc    = m_pc + 32'd4;
                    m_out_v = 0;
                end
                if (exp_req_v && imem_req_ready_i) begin
                    m_os = 1; m_stale = 0; m_os_addr = exp_addr;
                end
            end
        end
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; redirect_pc_i = '0; imem_req_ready_i = 1'b0;
        id_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        #1;

        // Request held while memory stalls for three cycles.
        chk("t3_req_v0", 64'(imem_req_valid_o), 64'(1));
        chk("t3_addr0", 64'(imem_req_addr_o), 64'(32'h8000_0000));
        for (int i = 1; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            chk("t3_req_v", 64'(imem_req_valid_o), 64'(1));
            chk("t3_addr", 64'(imem_req_addr_o), 64'(32'h8000_0000));
        end

        // First fetch: accept, respond next cycle, present to decode.
        cyc(0, 0, 1, 1);
        chk("t1_accept_addr", 64'(imem_req_addr_o), 64'(32'h8000_0000));
        mem_lat = 1; mem_dnext = 32'h0000_0013;
        cyc(0, 0, 0, 1);
        chk("t1_wait_if_v", 64'(if_valid_o), 64'(0));
        chk("t1_wait_req_v", 64'(imem_req_valid_o), 64'(0));
        cyc(0, 0, 0, 1);
        chk("t1_out_v", 64'(if_valid_o), 64'(1));
        chk("t1_out", ifToId_o, {32'h8000_0000, 32'h0000_0013});
        cyc(0, 0, 1, 0);
        chk("t1_next_req_v", 64'(imem_req_valid_o), 64'(1));
        chk("t1_next_addr", 64'(imem_req_addr_o), 64'(32'h8000_0004));

        // Decode back-pressure for five cycles.
        mem_lat = 1; mem_dnext = 32'h0010_0093;
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0);
            chk("t2_if_v", 64'(if_valid_o), 64'(1));
            chk("t2_out", ifToId_o, {32'h8000_0004, 32'h0010_0093});
            chk("t2_req_v", 64'(imem_req_valid_o), 64'(0));
        end
        cyc(0, 0, 0, 1);
        chk("t2_hs_if_v", 64'(if_valid_o), 64'(1));
        cyc(0, 0, 0, 0);
        chk("t2_next_addr", 64'(imem_req_addr_o), 64'(32'h8000_0008));

        // Flush beats the decode handshake in the output state.
        cyc(0, 0, 1, 0);
        mem_lat = 1; mem_dnext = 32'h0020_0113;
        cyc(0, 0, 0, 0);
        cyc(1, 32'h8000_2000, 1, 1);
        chk("t5_if_v", 64'(if_valid_o), 64'(0));
        chk("t5_req_v", 64'(imem_req_valid_o), 64'(0));
        cyc(0, 0, 0, 0);
        chk("t5_next_addr", 64'(imem_req_addr_o), 64'(32'h8000_2000));

        // Flush while waiting; the stale reply must never reach decode.
        cyc(0, 0, 1, 0);
        mem_lat = 3; mem_dnext = 32'hDEAD_BEEF;
        cyc(1, 32'h8000_1000, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t4_if_v_a", 64'(if_valid_o), 64'(0));
        cyc(0, 0, 0, 0);
        chk("t4_rsp_seen", 64'(imem_rsp_valid_i), 64'(1));
        chk("t4_if_v_b", 64'(if_valid_o), 64'(0));
        cyc(0, 0, 0, 0);
        chk("t4_if_v_c", 64'(if_valid_o), 64'(0));
        chk("t4_req_v", 64'(imem_req_valid_o), 64'(1));
        chk("t4_addr", 64'(imem_req_addr_o), 64'(32'h8000_1000));

        // Asynchronous reset while waiting, followed by a late reply.
        cyc(0, 0, 1, 0);
        mem_lat = 3; mem_dnext = 32'h1234_5678;
        cyc(0, 0, 0, 0);
        rst_i = 1'b1;
        #1;
        chk("t6_req_v", 64'(imem_req_valid_o), 64'(0));
        chk("t6_if_v", 64'(if_valid_o), 64'(0));
        chk("t6_out", ifToId_o, 64'(0));
        chk("t6_addr", 64'(imem_req_addr_o), 64'(32'h8000_0000));
        cyc(0, 0, 0, 0);
        rst_i = 1'b0;
        cyc(0, 0, 0, 0);
        chk("t6_late_if_v", 64'(if_valid_o), 64'(0));
        cyc(0, 0, 0, 0);
        chk("t6_after_if_v", 64'(if_valid_o), 64'(0));
        chk("t6_after_addr", 64'(imem_req_addr_o), 64'(32'h8000_0000));

        // Flush in the request state, then PC wrap past the top of the address space.
        cyc(1, 32'hFFFF_FFFC, 1, 0);
        chk("wrap_flush_req_v", 64'(imem_req_valid_o), 64'(0));
        cyc(0, 0, 1, 0);
        chk("wrap_addr", 64'(imem_req_addr_o), 64'(32'hFFFF_FFFC));
        mem_lat = 1; mem_dnext = 32'h0030_0193;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk("wrap_out", ifToId_o, {32'hFFFF_FFFC, 32'h0030_0193});
        cyc(0, 0, 0, 0);
        chk("wrap_next_addr", 64'(imem_req_addr_o), 64'(32'h0000_0000));

        // Randomized traffic scored by the model.
        hs_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rp;
            mem_lat   = $urandom_range(1, 3);
            mem_dnext = $urandom;
            rp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            cyc(($urandom_range(0, 15) == 0), rp, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
        end
        chk("random_progress", 64'(hs_cnt > 100), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
